fifo_counted: RTL and testbench

// - Parametrised synchronous FIFO, successor to the basic full/empty FIFO.
// - Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow

---
 rtl/fifo_counted.sv | 108 ++++++++++
 tb/tb_fifo_counted.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_counted.sv
// fifo_counted: single-clock FIFO with occupancy count, almost-full/empty flags, sticky errors and flush.
// Define FIFO_FWFT_EN for first-word-fall-through read_data; otherwise read_data is registered.
module fifo_counted #(
    parameter int unsigned address_bits       = 3,
    parameter int unsigned bits_per_word      = 8,
    parameter int unsigned almost_full_level  = 6,
    parameter int unsigned almost_empty_level = 1
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     write,
    input  logic [bits_per_word-1:0] write_data,
    input  logic                     read,
    output logic [bits_per_word-1:0] read_data,
    input  logic                     flush,
    input  logic                     clear_errors,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [address_bits:0]    count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int unsigned depth = 2 ** address_bits;
    localparam logic [address_bits:0] depth_cnt = (address_bits + 1)'(depth);
    localparam logic [address_bits:0] af_cnt    = (address_bits + 1)'(almost_full_level);
    localparam logic [address_bits:0] ae_cnt    = (address_bits + 1)'(almost_empty_level);

    logic [bits_per_word-1:0] mem [depth];
    logic [address_bits-1:0]  wr_ptr;
    logic [address_bits-1:0]  rd_ptr;
    logic                     wr_ok;
    logic                     rd_ok;
    logic                     ov_set;
    logic                     un_set;

    always_comb begin
        full         = (count == depth_cnt);
        empty        = (count == '0);
        almost_full  = (count >= af_cnt);
        almost_empty = (count <= ae_cnt);
    end

    // Acceptance is judged on the pre-edge count, so a read on empty never sees the same-cycle write.
    always_comb begin
        wr_ok  = write & ~full  & ~flush;
        rd_ok  = read  & ~empty & ~flush;
        ov_set = write & full   & ~flush;
        un_set = read  & empty  & ~flush;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new error in the same cycle as clear_errors leaves the flag set.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ov_set | (overflow  & ~clear_errors);
            underflow <= un_set | (underflow & ~clear_errors);
        end
    end

`ifdef FIFO_FWFT_EN
    always_comb begin
        read_data = mem[rd_ptr];
    end
`else
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            read_data <= '0;
        end else if (rd_ok) begin
            read_data <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_counted.sv
// Directed bench for fifo_counted (depth 8); build with or without FIFO_FWFT_EN.
module tb_fifo_counted;
    logic       clk;
    logic       areset;
    logic       write;
    logic [7:0] write_data;
    logic       read;
    logic [7:0] read_data;
    logic       flush;
    logic       clear_errors;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  q[$];
    logic [7:0]  last_rd;

    fifo_counted #(
        .address_bits      (3),
        .bits_per_word     (8),
        .almost_full_level (6),
        .almost_empty_level(1)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .write       (write),
        .write_data  (write_data),
        .read        (read),
        .read_data   (read_data),
        .flush       (flush),
        .clear_errors(clear_errors),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input int unsigned n);
        check({tag, ".count"}, 32'(count), 32'(n));
        check({tag, ".full"}, 32'(full), 32'(n == 8));
        check({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(n >= 6));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 1));
    endtask

    task automatic drive(input logic w, input logic [7:0] wd, input logic r,
                         input logic fl, input logic ce);
        @(negedge clk);
        write        = w;
        write_data   = wd;
        read         = r;
        flush        = fl;
        clear_errors = ce;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        write        = 1'b0;
        read         = 1'b0;
        flush        = 1'b0;
        clear_errors = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b0);
        tick();
        q.push_back(d);
    endtask

    task automatic do_read(input string tag);
        logic [7:0] exp;
        exp = q.pop_front();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
        check(tag, 32'(read_data), 32'(exp));
`endif
        tick();
`ifndef FIFO_FWFT_EN
        check(tag, 32'(read_data), 32'(exp));
`endif
        last_rd = exp;
    endtask

    initial begin
        logic [7:0] exp;
        areset = 1'b1;
        write = 1'b0; write_data = 8'h00; read = 1'b0; flush = 1'b0; clear_errors = 1'b0;
        last_rd = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 0);
        check("reset.overflow", 32'(overflow), 32'd0);
        check("reset.underflow", 32'(underflow), 32'd0);
`ifndef FIFO_FWFT_EN
        check("reset.read_data", 32'(read_data), 32'h00);
`endif
        @(negedge clk);
        areset = 1'b0;

        for (int i = 1; i <= 8; i++) begin
            do_write(8'(17 * i));
            check_state("fill", i);
`ifdef FIFO_FWFT_EN
            if (i == 1) check("fwft_head", 32'(read_data), 32'h11);
`endif
        end

        drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        tick();
        check("ovf.overflow", 32'(overflow), 32'd1);
        check_state("ovf", 8);

        for (int i = 1; i <= 8; i++) begin
            do_read("drain.data");
            check_state("drain", 8 - i);
        end

        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        check("udf.underflow", 32'(underflow), 32'd1);
        check_state("udf", 0);
`ifndef FIFO_FWFT_EN
        check("udf.read_data_hold", 32'(read_data), 32'h88);
`endif
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        check("clr.overflow", 32'(overflow), 32'd0);
        check("clr.underflow", 32'(underflow), 32'd0);

        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 5; k++) do_write(8'(8'hA0 + p * 8 + k));
            check_state("wrap.fill", 5);
            for (int k = 0; k < 5; k++) do_read("wrap.data");
            check_state("wrap.empty", 0);
        end

        for (int k = 0; k < 4; k++) do_write(8'(8'h40 + k));
        for (int k = 0; k < 20; k++) begin
            exp = q[0];
            drive(1'b1, 8'(8'h50 + k), 1'b1, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
            check("conc.data", 32'(read_data), 32'(exp));
`endif
            tick();
`ifndef FIFO_FWFT_EN
            check("conc.data", 32'(read_data), 32'(exp));
`endif
            void'(q.pop_front());
            q.push_back(8'(8'h50 + k));
            last_rd = exp;
            check("conc.count", 32'(count), 32'd4);
        end
        for (int k = 0; k < 4; k++) do_read("conc.drain");
        check_state("conc.empty", 0);

        for (int k = 0; k < 3; k++) do_write(8'(8'hD0 + k));
        drive(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        tick();
        q.delete();
        check_state("flush", 0);
        check("flush.overflow", 32'(overflow), 32'd0);
`ifndef FIFO_FWFT_EN
        check("flush.read_data_hold", 32'(read_data), 32'(last_rd));
`endif

        drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        tick();
        q.push_back(8'h77);
        check("wr_rd_empty.underflow", 32'(underflow), 32'd1);
        check_state("wr_rd_empty", 1);
`ifndef FIFO_FWFT_EN
        check("wr_rd_empty.read_data_hold", 32'(read_data), 32'(last_rd));
`endif
        do_read("wr_rd_empty.data");
        check_state("wr_rd_empty.drained", 0);

        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        check("clr2.underflow", 32'(underflow), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        check("set_wins.underflow", 32'(underflow), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        check("clr3.underflow", 32'(underflow), 32'd0);

        for (int k = 0; k < 8; k++) do_write(8'(8'hC0 + k));
        check_state("refill", 8);
        exp = q[0];
        drive(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
        check("wr_rd_full.data", 32'(read_data), 32'(exp));
`endif
        tick();
`ifndef FIFO_FWFT_EN
        check("wr_rd_full.data", 32'(read_data), 32'(exp));
`endif
        void'(q.pop_front());
        last_rd = exp;
        check("wr_rd_full.overflow", 32'(overflow), 32'd1);
        check_state("wr_rd_full", 7);

        do_read("pre_reset.data");
        do_read("pre_reset.data");
        check_state("pre_reset", 5);
        @(negedge clk);
        #2;
        areset = 1'b1;
        #1;
        check_state("async_reset", 0);
        check("async_reset.overflow", 32'(overflow), 32'd0);
`ifndef FIFO_FWFT_EN
        check("async_reset.read_data", 32'(read_data), 32'h00);
`endif
        @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        q.delete();
        do_write(8'h5A);
        check_state("post_reset", 1);
        do_read("post_reset.data");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
